tetris_stat_bcd_acc: RTL and testbench
======================================

// Module: tetris_stat_bcd_acc
// PURPOSE
//  Game statistics engine: keeps score, cleared lines, level and high score as packed BCD (digit 0 in
//  bits [3:0]); no binary-to-BCD conversion. Accepts one line-clear report per piece lock via a
//  valid/ready handshake. Score gain = base(lines) * current level, built by repeated BCD additions.
//  Sits between the playfield line-clear logic and the HUD/drop-speed logic.
// PARAMETERS
//  SCORE_DIGITS     6   BCD digits of score and high score
//  LINES_DIGITS     4   BCD digits of line counter
//  LEVEL_DIGITS     2   BCD digits of level
//  LINES_PER_LEVEL  10  lines needed per level-up; legal range 5..255
//  START_LEVEL      1   level after srst; legal range 1..MAX_LEVEL
//  MAX_LEVEL        99  saturation level; must be < 10**LEVEL_DIGITS
// PORTS
//  clk                 in   1                clock
//  srst                in   1                sync reset, active-high; asserted at new game
//  disappear_lines_i   in   3                lines cleared by this report (0..4)
//  update_valid_i      in   1                report valid
//  update_ready_o      out  1                engine idle; report accepted when valid & ready
//  hiscore_clr_i       in   1                clears high score; srst does not
//  score_o             out  SCORE_DIGITS*4   BCD score
//  lines_o             out  LINES_DIGITS*4   BCD total lines
//  level_o             out  LEVEL_DIGITS*4   BCD level
//  hiscore_o           out  SCORE_DIGITS*4   BCD high score
//  level_changed_o     out  1                1-cycle pulse on level increment
// BEHAVIOUR
//  Reset (srst): score_o=0, lines_o=0, level_o=START_LEVEL, level_changed_o=0,
//   update_ready_o=1, FSM=IDLE, internal accumulator and lines-in-level counter cleared. hiscore_o is
//   untouched. hiscore_clr_i clears it to 0 next cycle; srst wins if both are asserted.
//  Base points (BCD): 0->0, 1->100, 2->300, 3->700, 4->1500. Inputs 5..7 are handled as 0 lines;
//   the report is still consumed.
//  FSM: IDLE -> (accept, N>0) ACC -> COMMIT -> IDLE. IDLE -> (accept, N==0) COMMIT -> IDLE.
//   IDLE: ready=1. On accept, latch N, copy score_o into acc, load iteration count = binary level.
//   ACC: one full-width BCD add acc+=base(N) per cycle, exactly L cycles for level L. The level used
//    is the level before this report is applied.
//   COMMIT (1 cycle): score_o<=acc; lines_o<=lines_o+N (BCD); lil<=lil+N. If lil+N >= LINES_PER_LEVEL:
//    lil<=lil+N-LINES_PER_LEVEL and level++. At most one level-up per report, because N<=4<LPL.
//    hiscore_o<=score if new score > hiscore. Unsigned compare of packed BCD is valid.
//  Timing: accept at edge T. For N>0, ready is low for L+1 cycles and all outputs update together
//   at edge T+L+1. For N==0, ready is low for 1 cycle and values are unchanged.
//  Saturation: a carry out of the top score digit sets acc to all-9s, and acc stays there for the
//   rest of the report. Lines saturate at all-9s. Level saturates at MAX_LEVEL; at MAX_LEVEL there is
//   no increment and no pulse.
//  level_changed_o is registered and high exactly the cycle after the COMMIT that incremented level.
//  srst in any state aborts the report: no partial score is committed and reset values apply next
//   cycle.
//  update_valid_i while ready=0 is ignored and is not queued.
//  Internal binary level shadow is $clog2(MAX_LEVEL+1) wide, kept in lockstep with level_o.
// TESTING
//  1 srst -> score=000000, lines=0000, level=01, ready=1, hiscore keeps its prior value.
//  2 Level 1, N=1 -> ready low 2 cycles, then score=000100, lines=0001, no level pulse.
//  3 Level 3 (lines=20), N=4 -> ready low 4 cycles, score +004500, lines=0024, level stays 03.
//  4 lines=0008, level 01, N=4 -> lines=0012, level=02, level_changed_o high for 1 cycle;
//    then N=3 -> lines=0015, no pulse.
//  5 score=999000 at level 5, N=4 -> score=999999. lines=9998, N=3 -> 9999. At level 99 with
//    lil=9, N=1 -> level stays 99, no pulse.
//  6 srst mid-ACC -> report dropped, score=0. High score updates only on a strictly greater commit;
//    hiscore_clr_i -> 000000. N=5 -> no change, ready low 1 cycle.

Source files
------------

// File: rtl/tetris_stat_bcd_acc.sv
// Tetris statistics engine: packed-BCD score, lines, level and high score.
// Score gain is base(lines) * level, formed by one BCD addition per cycle.
module tetris_stat_bcd_acc #(
  parameter int SCORE_DIGITS    = 6,
  parameter int LINES_DIGITS    = 4,
  parameter int LEVEL_DIGITS    = 2,
  parameter int LINES_PER_LEVEL = 10,
  parameter int START_LEVEL     = 1,
  parameter int MAX_LEVEL       = 99
) (
  input  logic                      clk,
  input  logic                      srst,
  input  logic [2:0]                disappear_lines_i,
  input  logic                      update_valid_i,
  output logic                      update_ready_o,
  input  logic                      hiscore_clr_i,
  output logic [SCORE_DIGITS*4-1:0] score_o,
  output logic [LINES_DIGITS*4-1:0] lines_o,
  output logic [LEVEL_DIGITS*4-1:0] level_o,
  output logic [SCORE_DIGITS*4-1:0] hiscore_o,
  output logic                      level_changed_o
);

  localparam int SW  = SCORE_DIGITS * 4;
  localparam int LW  = LINES_DIGITS * 4;
  localparam int VW  = LEVEL_DIGITS * 4;
  localparam int BLW = $clog2(MAX_LEVEL + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_COMMIT} state_t;

  // One BCD digit add; result bit 4 is the decimal carry.
  function automatic logic [4:0] bcd_dig_add(input logic [3:0] a, input logic [3:0] b,
                                             input logic cin);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (s > 5'd9) s = s + 5'd6;
    return s;
  endfunction

  // Elaboration-time conversion of the start level constant only.
  function automatic logic [VW-1:0] level_const_bcd(input int v);
    logic [VW-1:0] r;
    int            t;
    r = '0;
    t = v;
    for (int i = 0; i < LEVEL_DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [VW-1:0] START_LEVEL_BCD = level_const_bcd(START_LEVEL);

  state_t           state_q, state_d;
  logic [2:0]       n_q, n_d;
  logic [BLW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]    acc_q, acc_d;
  logic [SW-1:0]    score_q, score_d;
  logic [LW-1:0]    lines_q, lines_d;
  logic [VW-1:0]    level_q, level_d;
  logic [BLW-1:0]   level_bin_q, level_bin_d;
  logic [7:0]       lil_q, lil_d;
  logic [SW-1:0]    hiscore_q, hiscore_d;
  logic             lvl_chg_q, lvl_chg_d;

  logic [SW-1:0]    base_s;
  logic [SW-1:0]    acc_sum_s;
  logic [LW-1:0]    lines_sum_s;
  logic [VW-1:0]    level_inc_s;
  logic [8:0]       lil_sum_s;

  // Base points for the latched line count, already in BCD.
  always_comb begin
    base_s = '0;
    case (n_q)
      3'd1:    base_s = SW'(16'h0100);
      3'd2:    base_s = SW'(16'h0300);
      3'd3:    base_s = SW'(16'h0700);
      3'd4:    base_s = SW'(16'h1500);
      default: base_s = '0;
    endcase
  end

  // Saturating BCD adders for the accumulator, line count and level.
  always_comb begin
    logic       c;
    logic [4:0] d;
    c = 1'b0;
    d = 5'd0;
    acc_sum_s = '0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      d = bcd_dig_add(acc_q[i*4 +: 4], base_s[i*4 +: 4], c);
      acc_sum_s[i*4 +: 4] = d[3:0];
      c = d[4];
    end
    if (c) acc_sum_s = {SCORE_DIGITS{4'h9}};

    c = 1'b0;
    lines_sum_s = '0;
    for (int i = 0; i < LINES_DIGITS; i++) begin
      d = bcd_dig_add(lines_q[i*4 +: 4], (i == 0) ? {1'b0, n_q} : 4'h0, c);
      lines_sum_s[i*4 +: 4] = d[3:0];
      c = d[4];
    end
    if (c) lines_sum_s = {LINES_DIGITS{4'h9}};

    // MAX_LEVEL fits in LEVEL_DIGITS, so the increment never carries out.
    c = 1'b1;
    level_inc_s = '0;
    for (int i = 0; i < LEVEL_DIGITS; i++) begin
      d = bcd_dig_add(level_q[i*4 +: 4], 4'h0, c);
      level_inc_s[i*4 +: 4] = d[3:0];
      c = d[4];
    end

    lil_sum_s = {1'b0, lil_q} + {6'd0, n_q};
  end

  // Report FSM and next-state of all statistics.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    score_d     = score_q;
    lines_d     = lines_q;
    level_d     = level_q;
    level_bin_d = level_bin_q;
    lil_d       = lil_q;
    hiscore_d   = hiscore_q;
    lvl_chg_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (update_valid_i) begin
          n_d   = (disappear_lines_i <= 3'd4) ? disappear_lines_i : 3'd0;
          acc_d = score_q;
          cnt_d = level_bin_q;
          if (n_d != 3'd0) state_d = S_ACC;
          else             state_d = S_COMMIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACC: begin
        acc_d = acc_sum_s;
        cnt_d = cnt_q - BLW'(1);
        if (cnt_q == BLW'(1)) state_d = S_COMMIT;
        else                  state_d = S_ACC;
      end
      S_COMMIT: begin
        score_d = acc_q;
        lines_d = lines_sum_s;
        if (lil_sum_s >= 9'(LINES_PER_LEVEL)) begin
          lil_d = 8'(lil_sum_s - 9'(LINES_PER_LEVEL));
          if (level_bin_q < BLW'(MAX_LEVEL)) begin
            level_bin_d = level_bin_q + BLW'(1);
            level_d     = level_inc_s;
            lvl_chg_d   = 1'b1;
          end else begin
            level_bin_d = level_bin_q;
          end
        end else begin
          lil_d = lil_sum_s[7:0];
        end
        if (acc_q > hiscore_q) hiscore_d = acc_q;
        else                   hiscore_d = hiscore_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A clear request overrides a concurrent high-score update.
    if (hiscore_clr_i) hiscore_d = '0;
    else               hiscore_d = hiscore_d;
  end

  // Game-state registers; srst starts a new game.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= S_IDLE;
      n_q         <= 3'd0;
      cnt_q       <= '0;
      acc_q       <= '0;
      score_q     <= '0;
      lines_q     <= '0;
      level_q     <= START_LEVEL_BCD;
      level_bin_q <= BLW'(START_LEVEL);
      lil_q       <= 8'd0;
      lvl_chg_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      score_q     <= score_d;
      lines_q     <= lines_d;
      level_q     <= level_d;
      level_bin_q <= level_bin_d;
      lil_q       <= lil_d;
      lvl_chg_q   <= lvl_chg_d;
    end
  end

  // High score survives new games; srst freezes it for that cycle.
  always_ff @(posedge clk) begin
    if (srst) hiscore_q <= hiscore_q;
    else      hiscore_q <= hiscore_d;
  end

  assign update_ready_o  = (state_q == S_IDLE);
  assign score_o         = score_q;
  assign lines_o         = lines_q;
  assign level_o         = level_q;
  assign hiscore_o       = hiscore_q;
  assign level_changed_o = lvl_chg_q;

endmodule

// File: tb/tb_tetris_stat_bcd_acc.sv
// Self-checking bench for tetris_stat_bcd_acc: directed table, reset/high-score
// sequences and a randomized run against a decimal reference model.
module tb_tetris_stat_bcd_acc;

  logic        clk;
  logic        srst;
  logic [2:0]  disappear_lines_i;
  logic        update_valid_i;
  logic        update_ready_o;
  logic        hiscore_clr_i;
  logic [23:0] score_o;
  logic [11:0] lines_o;
  logic [7:0]  level_o;
  logic [23:0] hiscore_o;
  logic        level_changed_o;

  // Three line digits so line saturation is reachable within the run.
  tetris_stat_bcd_acc #(.LINES_DIGITS(3)) dut (
    .clk(clk), .srst(srst),
    .disappear_lines_i(disappear_lines_i), .update_valid_i(update_valid_i),
    .update_ready_o(update_ready_o), .hiscore_clr_i(hiscore_clr_i),
    .score_o(score_o), .lines_o(lines_o), .level_o(level_o),
    .hiscore_o(hiscore_o), .level_changed_o(level_changed_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Decimal reference model.
  int m_score, m_lines, m_level, m_lil, m_hi;

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_score = 0; m_lines = 0; m_level = 1; m_lil = 0;
  endtask

  task automatic model_step(input int n, output int eb, output bit ep);
    int ne, base;
    ne = (n <= 4) ? n : 0;
    case (ne)
      1: base = 100;
      2: base = 300;
      3: base = 700;
      4: base = 1500;
      default: base = 0;
    endcase
    eb = (ne > 0) ? m_level + 1 : 1;
    m_score = m_score + base * m_level;
    if (m_score > 999999) m_score = 999999;
    m_lines = m_lines + ne;
    if (m_lines > 999) m_lines = 999;
    m_lil = m_lil + ne;
    ep = 1'b0;
    if (m_lil >= 10) begin
      m_lil = m_lil - 10;
      if (m_level < 99) begin
        m_level = m_level + 1;
        ep = 1'b1;
      end
    end
    if (m_score > m_hi) m_hi = m_score;
  endtask

  // Handshake one report; spam drives valid during busy cycles.
  task automatic apply(input int n, input bit spam, output int busy, output logic pulse);
    int w;
    w = 0;
    while (!update_ready_o && w < 300) begin
      w++;
      @(negedge clk);
    end
    disappear_lines_i = 3'(n);
    update_valid_i    = 1'b1;
    @(negedge clk);
    update_valid_i = spam;
    if (spam) disappear_lines_i = 3'd4;
    busy = 0;
    while (!update_ready_o && busy < 200) begin
      busy++;
      @(negedge clk);
    end
    update_valid_i = 1'b0;
    pulse = level_changed_o;
  endtask

  task automatic run_report(input int n, input bit spam, output int busy, output logic pulse);
    int eb;
    bit ep;
    model_step(n, eb, ep);
    apply(n, spam, busy, pulse);
    chk("busy_cycles", busy, eb);
    chk("level_pulse", {31'd0, pulse}, {31'd0, ep});
    chk("score", {8'd0, score_o}, to_bcd(m_score));
    chk("lines", {20'd0, lines_o}, to_bcd(m_lines));
    chk("level", {24'd0, level_o}, to_bcd(m_level));
    chk("hiscore", {8'd0, hiscore_o}, to_bcd(m_hi));
    @(negedge clk);
    chk("pulse_drop", {31'd0, level_changed_o}, 32'd0);
  endtask

  typedef struct {
    int          n;
    logic [23:0] score;
    logic [11:0] lines;
    logic [7:0]  level;
    int          busy;
    logic        pulse;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int   busy;
    logic pulse;
    int   tail;
    int   n;
    bit   spam;

    tbl[0]  = '{1, 24'h000100, 12'h001, 8'h01, 2, 1'b0};
    tbl[1]  = '{0, 24'h000100, 12'h001, 8'h01, 1, 1'b0};
    tbl[2]  = '{5, 24'h000100, 12'h001, 8'h01, 1, 1'b0};
    tbl[3]  = '{4, 24'h001600, 12'h005, 8'h01, 2, 1'b0};
    tbl[4]  = '{3, 24'h002300, 12'h008, 8'h01, 2, 1'b0};
    tbl[5]  = '{4, 24'h003800, 12'h012, 8'h02, 2, 1'b1};
    tbl[6]  = '{3, 24'h005200, 12'h015, 8'h02, 3, 1'b0};
    tbl[7]  = '{2, 24'h005800, 12'h017, 8'h02, 3, 1'b0};
    tbl[8]  = '{4, 24'h008800, 12'h021, 8'h03, 3, 1'b1};
    tbl[9]  = '{4, 24'h013300, 12'h025, 8'h03, 4, 1'b0};
    tbl[10] = '{7, 24'h013300, 12'h025, 8'h03, 1, 1'b0};

    clk = 1'b0; srst = 1'b1; update_valid_i = 1'b0;
    disappear_lines_i = 3'd0; hiscore_clr_i = 1'b0;
    repeat (2) @(negedge clk);
    srst = 1'b0;
    hiscore_clr_i = 1'b1;
    @(negedge clk);
    hiscore_clr_i = 1'b0;
    model_reset();
    m_hi = 0;
    chk("rst_score", {8'd0, score_o}, 32'h0);
    chk("rst_lines", {20'd0, lines_o}, 32'h0);
    chk("rst_level", {24'd0, level_o}, 32'h01);
    chk("rst_ready", {31'd0, update_ready_o}, 32'd1);
    chk("rst_pulse", {31'd0, level_changed_o}, 32'd0);
    chk("hiscore_clr", {8'd0, hiscore_o}, 32'h0);

    for (int i = 0; i < 11; i++) begin
      run_report(tbl[i].n, 1'b0, busy, pulse);
      chk("tbl_busy", busy, tbl[i].busy);
      chk("tbl_pulse", {31'd0, pulse}, {31'd0, tbl[i].pulse});
      chk("tbl_score", {8'd0, score_o}, {8'd0, tbl[i].score});
      chk("tbl_lines", {20'd0, lines_o}, {20'd0, tbl[i].lines});
      chk("tbl_level", {24'd0, level_o}, {24'd0, tbl[i].level});
    end
    chk("tbl_hiscore", {8'd0, hiscore_o}, 32'h013300);

    // srst in the middle of an accumulation drops the report.
    disappear_lines_i = 3'd4;
    update_valid_i = 1'b1;
    @(negedge clk);
    update_valid_i = 1'b0;
    chk("mid_busy", {31'd0, update_ready_o}, 32'd0);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    model_reset();
    chk("abort_score", {8'd0, score_o}, 32'h0);
    chk("abort_lines", {20'd0, lines_o}, 32'h0);
    chk("abort_level", {24'd0, level_o}, 32'h01);
    chk("abort_ready", {31'd0, update_ready_o}, 32'd1);
    chk("abort_hiscore", {8'd0, hiscore_o}, 32'h013300);
    repeat (6) @(negedge clk);
    chk("abort_no_commit", {8'd0, score_o}, 32'h0);

    // Lower score keeps the high score; spammed valid while busy is ignored.
    run_report(1, 1'b1, busy, pulse);
    chk("hi_not_greater", {8'd0, hiscore_o}, 32'h013300);
    repeat (3) @(negedge clk);
    chk("spam_ignored", {8'd0, score_o}, 32'h000100);

    // srst wins over a simultaneous clear, then a lone clear zeroes it.
    srst = 1'b1; hiscore_clr_i = 1'b1;
    @(negedge clk);
    srst = 1'b0; hiscore_clr_i = 1'b0;
    model_reset();
    chk("srst_wins_hi", {8'd0, hiscore_o}, 32'h013300);
    chk("srst_score", {8'd0, score_o}, 32'h0);
    hiscore_clr_i = 1'b1;
    @(negedge clk);
    hiscore_clr_i = 1'b0;
    m_hi = 0;
    chk("hi_clear", {8'd0, hiscore_o}, 32'h0);

    // Randomized run up to level, line and score saturation.
    tail = 0;
    for (int i = 0; i < 800 && tail < 12; i++) begin
      n    = ($urandom_range(0, 9) < 6) ? 4 : int'($urandom_range(0, 7));
      spam = ($urandom_range(0, 3) == 0);
      run_report(n, spam, busy, pulse);
      if (m_level == 99 && m_lines == 999) tail++;
    end
    chk("sat_level", {24'd0, level_o}, 32'h99);
    chk("sat_lines", {20'd0, lines_o}, 32'h999);
    chk("sat_score", {8'd0, score_o}, 32'h999999);
    chk("sat_hiscore", {8'd0, hiscore_o}, 32'h999999);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
